alu_result_stats: RTL and testbench
===================================

# alu_result_stats

Downstream consumer of the 4-bit ALU result stream. Accepts signed 5-bit ALU results (C) through a valid/ready handshake and groups them into frames of FRAME_LEN samples. For each frame it computes the signed sum, minimum, maximum and sample count, then presents them on a held output handshake. It sits directly after the ALU in the datapath and feeds the result-reporting/scoreboard stage.

## Interface
- DATA_W, 5, width of signed ALU result input (matches ALU output C)
- FRAME_LEN, 8, samples per frame (2..255)
- SUM_W, 13, width of signed frame sum (must be ≥ DATA_W + clog2(FRAME_LEN))
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid ALU result
- in_data  input  DATA_W  signed 2's-complement ALU result
- in_ready  output  1  block can accept a sample this cycle
- flush  input  1  close current partial frame early
- out_valid  output  1  frame statistics valid and held
- out_ready  input  1  downstream accepts frame statistics
- out_sum  output  SUM_W  signed sum of frame samples
- out_min  output  DATA_W  signed minimum of frame samples
- out_max  output  DATA_W  signed maximum of frame samples
- out_count  output  8  number of samples in frame (1..FRAME_LEN)
- out_frame_id  output  8  frame sequence number, wraps 255→0

## Operation
- FSM states: ACCUM, HOLD. Reset state ACCUM.
- ACCUM: in_ready=1, out_valid=0. Sample accepted when in_valid && in_ready.
  - First accepted sample of frame: sum←sext(in_data), min←max←in_data, cnt←1.
  - Later samples: sum←sum+sext(in_data); min/max updated by signed compare; cnt←cnt+1.
  - Frame closes when the accepted sample makes cnt==FRAME_LEN, or flush=1 with (cnt>0 or a sample accepted this cycle). Closing latches outputs (including the sample accepted that cycle) and moves to HOLD.
  - flush with cnt==0 and no sample accepted: ignored, no empty frame produced.
- HOLD: in_ready=0, out_valid=1; out_* stable. On out_ready=1: go to ACCUM, clear cnt/sum, out_frame_id increments (mod 256). flush ignored in HOLD.
- Arithmetic: all sign-extended signed; SUM_W sized so no overflow is possible; no saturation.
- out_frame_id of first frame after reset is 0.

## Timing
- Reset (sync, active-high) values: state=ACCUM, in_ready=1 in the cycle after reset deasserts (0 while reset is held), out_valid=0, out_sum=0, out_min=0, out_max=0, out_count=0, out_frame_id=0, internal cnt=0.
- Reset mid-frame or in HOLD: partial frame and pending output discarded; no out_valid afterwards until a new frame completes.
- Latency: out_valid rises the cycle after the closing sample/flush edge.
- One sample per cycle max; full frame of FRAME_LEN back-to-back samples takes FRAME_LEN cycles, then ≥1 HOLD cycle.
- Release: HOLD lasts until out_ready sampled high; in_ready returns to 1 the cycle after the handshake (no same-cycle accept during release).
- out_* must not change while out_valid=1 and out_ready=0.
- in_valid while in_ready=0: no effect; upstream must hold data.

## Test plan
- Reset: hold reset 2 cycles -> all outputs 0, out_valid=0; one cycle after release in_ready=1.
- Full frame: 8 back-to-back samples 3,-4,7,-8,15,-16,0,1, out_ready=1 -> next cycle out_valid=1, out_sum=-2, out_min=-16, out_max=15, out_count=8, out_frame_id=0; second frame gets id 1.
- Backpressure: complete frame with out_ready=0 for 5 cycles -> in_ready=0, outputs stable all 5 cycles; in_valid pulses during HOLD ignored; out_ready=1 -> released, next frame starts clean.
- Flush: samples 5,-2,9 then flush with in_valid=1, in_data=-1 -> out_count=4, out_sum=11, out_min=-2, out_max=9; flush with cnt=0 -> no out_valid.
- Reset mid-frame: 4 samples, reset 1 cycle, then 8 samples of 1 -> single frame out_sum=8, out_count=8, out_frame_id=0.
- Extremes/wrap: 8 samples of -16 -> out_sum=-128; 256 frames -> out_frame_id wraps 255→0.

Source files
------------

// File: rtl/alu_result_stats.sv
// alu_result_stats: groups signed ALU results into frames and reports the sum, minimum,
// maximum, sample count and sequence number of each frame on a held output handshake.
module alu_result_stats #(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned SUM_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [7:0]        out_count,
  output logic [7:0]        out_frame_id
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e state_q, state_d;

  logic signed [SUM_W-1:0]  sum_q, sum_d, sum_acc;
  logic signed [DATA_W-1:0] min_q, min_d, min_acc;
  logic signed [DATA_W-1:0] max_q, max_d, max_acc;
  logic signed [DATA_W-1:0] din;
  logic [7:0]               cnt_q, cnt_d, cnt_acc;

  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_min_q, out_min_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic [7:0]        out_count_q, out_count_d;
  logic [7:0]        frame_id_q, frame_id_d;

  logic accept;
  logic close;

  assign din = $signed(in_data);

  // Accumulator values if the current input sample were accepted this cycle.
  always_comb begin
    if (cnt_q == 8'd0) begin
      sum_acc = {{(SUM_W-DATA_W){din[DATA_W-1]}}, din};
      min_acc = din;
      max_acc = din;
      cnt_acc = 8'd1;
    end else begin
      sum_acc = sum_q + {{(SUM_W-DATA_W){din[DATA_W-1]}}, din};
      min_acc = (din < min_q) ? din : min_q;
      max_acc = (din > max_q) ? din : max_q;
      cnt_acc = cnt_q + 8'd1;
    end
  end

  // Next-state, frame closing and handshake outputs.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    min_d       = min_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_min_d   = out_min_q;
    out_max_d   = out_max_q;
    out_count_d = out_count_q;
    frame_id_d  = frame_id_q;
    close       = 1'b0;
    // in_ready is low while reset is held, even though the state is already StAccum.
    in_ready    = (state_q == StAccum) && !reset;
    out_valid   = (state_q == StHold);
    accept      = in_valid && in_ready;

    unique case (state_q)
      StAccum: begin
        if (accept) begin
          sum_d = sum_acc;
          min_d = min_acc;
          max_d = max_acc;
          cnt_d = cnt_acc;
        end
        // A flush on an empty frame with no sample this cycle produces nothing.
        close = (accept && (cnt_acc == 8'(FRAME_LEN))) || (flush && ((cnt_q != 8'd0) || accept));
        if (close) begin
          out_sum_d   = sum_d;
          out_min_d   = min_d;
          out_max_d   = max_d;
          out_count_d = cnt_d;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d    = StAccum;
          cnt_d      = 8'd0;
          sum_d      = '0;
          frame_id_d = frame_id_q + 8'd1;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAccum;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      cnt_q       <= 8'd0;
      out_sum_q   <= '0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      out_count_q <= 8'd0;
      frame_id_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_min_q   <= out_min_d;
      out_max_q   <= out_max_d;
      out_count_q <= out_count_d;
      frame_id_q  <= frame_id_d;
    end
  end

  assign out_sum      = out_sum_q;
  assign out_min      = out_min_q;
  assign out_max      = out_max_q;
  assign out_count    = out_count_q;
  assign out_frame_id = frame_id_q;

endmodule

// File: tb/tb_alu_result_stats.sv
// Directed bench for alu_result_stats with a scoreboard of expected frames.
module tb_alu_result_stats;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_sum;
  logic [4:0]  out_min;
  logic [4:0]  out_max;
  logic [7:0]  out_count;
  logic [7:0]  out_frame_id;

  alu_result_stats #(
    .DATA_W   (5),
    .FRAME_LEN(8),
    .SUM_W    (13)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_min     (out_min),
    .out_max     (out_max),
    .out_count   (out_count),
    .out_frame_id(out_frame_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int mn;
    int mx;
    int cnt;
    int id;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] next_id;
  int         n_assert;
  int         n_fail;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input starting from a falling edge.
  task automatic drive(input int d, input logic fl, input logic v);
    in_valid = v;
    in_data  = d[4:0];
    flush    = fl;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expect_frame(input int sum, input int mn, input int mx, input int cnt);
    exp_t e;
    e.sum = sum;
    e.mn  = mn;
    e.mx  = mx;
    e.cnt = cnt;
    e.id  = int'(next_id);
    sb.push_back(e);
    next_id++;
  endtask

  // Wait for a frame, compare it against the scoreboard, hold it for `hold` cycles, release.
  task automatic collect(input int hold);
    exp_t e;
    int   waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("latency", waited, 0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (out_valid !== 1'b1) return;
    chk("sum", $signed(out_sum), e.sum);
    chk("min", $signed(out_min), e.mn);
    chk("max", $signed(out_max), e.mx);
    chk("count", out_count, e.cnt);
    chk("frame_id", out_frame_id, e.id);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 5'd7;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", $signed(out_sum), e.sum);
      chk("hold_count", out_count, e.cnt);
      chk("hold_id", out_frame_id, e.id);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    int v;
    n_assert  = 0;
    n_fail    = 0;
    next_id   = 8'd0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 5'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", $signed(out_sum), 0);
    chk("rst_min", $signed(out_min), 0);
    chk("rst_max", $signed(out_max), 0);
    chk("rst_count", out_count, 0);
    chk("rst_id", out_frame_id, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Full frame of back-to-back samples.
    drive(3, 0, 1);
    drive(-4, 0, 1);
    drive(7, 0, 1);
    drive(-8, 0, 1);
    drive(15, 0, 1);
    drive(-16, 0, 1);
    drive(0, 0, 1);
    drive(1, 0, 1);
    expect_frame(-2, -16, 15, 8);
    collect(0);

    // Second frame held under backpressure for 5 cycles.
    for (int i = 1; i <= 8; i++) drive(i, 0, 1);
    expect_frame(36, 1, 8, 8);
    collect(5);

    // Flush together with a final sample.
    drive(5, 0, 1);
    drive(-2, 0, 1);
    drive(9, 0, 1);
    drive(-1, 1, 1);
    expect_frame(11, -2, 9, 4);
    collect(0);

    // Flush on an empty frame produces nothing.
    drive(0, 1, 0);
    chk("empty_flush_valid", out_valid, 0);
    @(negedge clk);
    chk("empty_flush_valid2", out_valid, 0);

    // Flush with no sample on a partial frame.
    drive(2, 0, 1);
    drive(3, 0, 1);
    drive(0, 1, 0);
    expect_frame(5, 2, 3, 2);
    collect(0);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 4; i++) drive(-5, 0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    reset   = 1'b0;
    next_id = 8'd0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_sum", $signed(out_sum), 0);
    chk("mid_rst_id", out_frame_id, 0);
    @(negedge clk);
    chk("mid_rst_idle_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) drive(1, 0, 1);
    expect_frame(8, 1, 1, 8);
    collect(0);

    // Most negative samples.
    for (int i = 0; i < 8; i++) drive(-16, 0, 1);
    expect_frame(-128, -16, -16, 8);
    collect(0);

    // 256 more frames so the frame id wraps through 255 -> 0.
    for (int k = 0; k < 256; k++) begin
      v = (k % 32) - 16;
      for (int i = 0; i < 8; i++) drive(v, 0, 1);
      expect_frame(8 * v, v, v, 8);
      collect(0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
